// File: rtl/sic_pkg.sv
// Shared types and constants for the SIC memory responder slice.
package sic_pkg;

  localparam int SIC_ADDR_W = 15;
  localparam int SIC_DATA_W = 24;
  localparam int WAIT_CNT_W = 4;

  typedef logic [SIC_ADDR_W-1:0] addr_t;
  typedef logic [SIC_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } resp_state_t;

  // True when a word address falls inside the implemented array.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return (addr < words);
  endfunction

endpackage

// File: rtl/sic_mem_array.sv
// Single-port synchronous word array: write enable, registered read.
// Addresses wrap modulo MEM_WORDS; contents are never reset.
module sic_mem_array #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 24,
  parameter int MEM_WORDS  = 32768
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [IDX_W-1:0]      w_idx;

  assign w_idx = IDX_W'(32'(i_addr) % 32'(MEM_WORDS));

  // Array write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[w_idx] <= i_wdata;
    end
    o_rdata <= r_mem[w_idx];
  end

endmodule

// File: rtl/sic_mem_responder.sv
// Memory-side responder for the SIC CPU memory port: one outstanding word
// request, WAIT_STATES wait cycles, one access cycle, then a held response.
// Optional feature macro: SIC_MEM_RANGE_CHECK_EN (reject req_addr >= MEM_WORDS).
module sic_mem_responder
  import sic_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 24,
  parameter int MEM_WORDS   = 32768,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

  resp_state_t           r_state;
  resp_state_t           w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cnt_nxt;
  logic                  w_accept;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  w_in_range;
  logic                  w_arr_we;
  logic [ADDR_WIDTH-1:0] w_arr_addr;
  logic [DATA_WIDTH-1:0] w_arr_rdata;

`ifdef SIC_MEM_RANGE_CHECK_EN
  assign w_in_range = addr_in_range(32'(r_addr), MEM_WORDS);
`else
  assign w_in_range = 1'b1;
`endif

  // In IDLE the array looks at the incoming address so its registered read
  // is already valid in ACCESS even with zero wait states.
  assign w_arr_addr = (r_state == IDLE) ? req_addr : r_addr;
  assign w_arr_we   = (r_state == ACCESS) && r_we && w_in_range;

  sic_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk    (clk),
    .i_we   (w_arr_we),
    .i_addr (w_arr_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_arr_rdata)
  );

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (WS_LOAD == {WAIT_CNT_W{1'b0}}) begin
            w_state_nxt = ACCESS;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WS_LOAD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
        if (r_cnt == WAIT_CNT_W'(1)) begin
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      ACCESS: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {WAIT_CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, wait counter and registered handshake flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= {WAIT_CNT_W{1'b0}};
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
    end
  end

  // Latch the request fields on acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_we    <= 1'b0;
      r_wdata <= {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_we    <= req_we;
      r_wdata <= req_wdata;
    end
  end

  // Load the response registers in ACCESS; they hold through RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= {DATA_WIDTH{1'b0}};
      r_err   <= 1'b0;
    end else if (r_state == ACCESS) begin
      if (!w_in_range) begin
        r_rdata <= {DATA_WIDTH{1'b0}};
        r_err   <= 1'b1;
      end else if (r_we) begin
        r_rdata <= r_wdata;
        r_err   <= 1'b0;
      end else begin
        r_rdata <= w_arr_rdata;
        r_err   <= 1'b0;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_sic_mem_responder.sv
// Scoreboard bench for sic_mem_responder: four instances with different
// WAIT_STATES / MEM_WORDS, exercised one at a time; a monitor compares each
// presented response against the queue of expected results.
module tb_sic_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [3:0]  rsp_ready;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_err;
  logic [14:0] req_addr  [4];
  logic [23:0] req_wdata [4];
  logic [23:0] rsp_rdata [4];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int sel   = 0;
  bit prev_v = 1'b0;

  typedef struct {
    logic [23:0] d;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 15 : 3;
    localparam int MW = (g == 0) ? 1024 : 32768;
    sic_mem_responder #(
      .ADDR_WIDTH (15),
      .DATA_WIDTH (24),
      .MEM_WORDS  (MW),
      .WAIT_STATES(WS)
    ) u_dut (
      .clk      (clk),
      .rst      (rst_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_we   (req_we[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  function automatic int ws_of(input int g);
    case (g)
      0: return 1;
      1: return 0;
      2: return 15;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout at cycle %0d", nm, cyc);
  endtask

  // Issue one request (called at posedge+1) and queue its expected response
  task automatic do_req(input int g, input logic [14:0] a, input logic we,
                        input logic [23:0] d, input logic [23:0] ed, input logic ee);
    exp_t x;
    int   n;
    n = 0;
    while (req_ready[g] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      tmo("req_ready_wait");
    end else begin
      req_valid[g] = 1'b1;
      req_addr[g]  = a;
      req_we[g]    = we;
      req_wdata[g] = d;
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      x.d   = ed;
      x.e   = ee;
      x.lat = ws_of(g) + 1;
      x.acc = cyc;
      sb_q.push_back(x);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      tmo("response_drain");
      sb_q.delete();
    end
  endtask

  // Monitor: compare every presented response cycle with the queue head
  always @(negedge clk) begin
    exp_t h;
    if (rsp_valid[sel] === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h with no request pending", rsp_rdata[sel]);
      end else begin
        h = sb_q[0];
        if (!prev_v) chk("latency", 32'(cyc - h.acc), 32'(h.lat));
        chk("rsp_rdata", 32'(rsp_rdata[sel]), 32'(h.d));
        chk("rsp_err", 32'(rsp_err[sel]), 32'(h.e));
        if (rsp_ready[sel] === 1'b1) begin
          h = sb_q.pop_front();
        end
      end
    end
    prev_v = (rsp_valid[sel] === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 4'h0;
    req_valid = 4'h0;
    req_we    = 4'h0;
    rsp_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_addr[i]  = 15'h0;
      req_wdata[i] = 24'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_req_ready%0d", g), 32'(req_ready[g]), 32'd1);
      chk($sformatf("reset_rsp_valid%0d", g), 32'(rsp_valid[g]), 32'd0);
      chk($sformatf("reset_rsp_rdata%0d", g), 32'(rsp_rdata[g]), 32'd0);
      chk($sformatf("reset_rsp_err%0d", g), 32'(rsp_err[g]), 32'd0);
    end
    rst_n = 4'hF;
    @(posedge clk); #1;

    // Write then read back, WAIT_STATES=1
    sel = 0;
    do_req(0, 15'h0010, 1'b1, 24'hABCDEF, 24'hABCDEF, 1'b0);
    do_req(0, 15'h0010, 1'b0, 24'h000000, 24'hABCDEF, 1'b0);
    wait_done();

    // Out-of-range write on a 1024-word array
    do_req(0, 15'h0000, 1'b1, 24'h555555, 24'h555555, 1'b0);
`ifdef SIC_MEM_RANGE_CHECK_EN
    do_req(0, 15'h0400, 1'b1, 24'h0000AA, 24'h000000, 1'b1);
    do_req(0, 15'h0000, 1'b0, 24'h000000, 24'h555555, 1'b0);
    do_req(0, 15'h0400, 1'b0, 24'h000000, 24'h000000, 1'b1);
`else
    do_req(0, 15'h0400, 1'b1, 24'h0000AA, 24'h0000AA, 1'b0);
    do_req(0, 15'h0000, 1'b0, 24'h000000, 24'h0000AA, 1'b0);
    do_req(0, 15'h0400, 1'b0, 24'h000000, 24'h0000AA, 1'b0);
`endif
    wait_done();

    // Response back-pressure, WAIT_STATES=0
    sel = 1;
    rsp_ready[1] = 1'b0;
    do_req(1, 15'h0005, 1'b1, 24'h13579B, 24'h13579B, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid[1] !== 1'b1 && n < 20);
    if (rsp_valid[1] !== 1'b1) tmo("bp_rsp_valid");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid[1]), 32'd1);
      chk("bp_rsp_rdata", 32'(rsp_rdata[1]), 32'h13579B);
      chk("bp_req_ready", 32'(req_ready[1]), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_at_rise", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    chk("bp_req_ready_after", 32'(req_ready[1]), 32'd1);
    chk("bp_rsp_valid_after", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk); #1;
    do_req(1, 15'h0005, 1'b0, 24'h000000, 24'h13579B, 1'b0);
    wait_done();

    // Long wait, top address, WAIT_STATES=15
    sel = 2;
    do_req(2, 15'h7FFF, 1'b1, 24'h123456, 24'h123456, 1'b0);
    do_req(2, 15'h7FFF, 1'b0, 24'h000000, 24'h123456, 1'b0);
    wait_done();

    // Reset during WAIT aborts a write, WAIT_STATES=3
    sel = 3;
    do_req(3, 15'h0020, 1'b1, 24'h0F0F0F, 24'h0F0F0F, 1'b0);
    wait_done();
    req_valid[3] = 1'b1;
    req_addr[3]  = 15'h0020;
    req_we[3]    = 1'b1;
    req_wdata[3] = 24'h000001;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(posedge clk); #1;
    chk("abort_req_ready_busy", 32'(req_ready[3]), 32'd0);
    rst_n[3] = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready[3]), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid[3]), 32'd0);
    chk("abort_rsp_rdata", 32'(rsp_rdata[3]), 32'd0);
    chk("abort_rsp_err", 32'(rsp_err[3]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    @(posedge clk); #1;
    do_req(3, 15'h0020, 1'b0, 24'h000000, 24'h0F0F0F, 1'b0);
    wait_done();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
